// File: rtl/minisys_pkg.sv
// Shared Minisys constants: CTC register offsets and ctrl/status bit positions.
package minisys_pkg;

    localparam logic [1:0] CTC_CTRL0 = 2'd0;
    localparam logic [1:0] CTC_CTRL1 = 2'd1;
    localparam logic [1:0] CTC_CNT0  = 2'd2;
    localparam logic [1:0] CTC_CNT1  = 2'd3;

    localparam int CTRL_MODE   = 0;
    localparam int CTRL_RELOAD = 1;

    localparam int STAT_DONE = 0;
    localparam int STAT_RUN  = 1;

    localparam int CTC_CHANNELS = 2;

endpackage

// File: rtl/minisys_ctc_if.sv
// CPU-side register bus of the CTC: decoder select, strobes, address and data.
interface minisys_ctc_if #(
    parameter int WIDTH = 16
);
    logic             cs;
    logic [1:0]       addr;
    logic             iow;
    logic             ior;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;

    modport master (output cs, addr, iow, ior, wdata, input rdata);
    modport slave  (input cs, addr, iow, ior, wdata, output rdata);
endinterface

// File: rtl/minisys_ctc_channel.sv
// One CTC channel: pulse synchronizer, edge detect, down-counter, expiry and strobe.
module ctc_channel
    import minisys_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             pulse,
    input  logic             ctrl_wr,
    input  logic             init_wr,
    input  logic             stat_rd,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] status,
    output logic [WIDTH-1:0] count,
    output logic             cout
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]             ctrl;
    logic [WIDTH-1:0]       init;
    logic                   running;
    logic                   done;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_q;
    logic                   pulse_rise;
    logic                   dec;
    logic                   expire;

    assign pulse_rise = sync[SYNC_STAGES-1] & ~sync_q;
    assign dec        = running & (ctrl[CTRL_MODE] ? pulse_rise : 1'b1);
    assign expire     = dec & (count == ONE);

    always_comb begin
        status            = '0;
        status[STAT_DONE] = done;
        status[STAT_RUN]  = running;
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            ctrl    <= '0;
            init    <= '0;
            count   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            cout    <= 1'b0;
            sync    <= '0;
            sync_q  <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], pulse};
            sync_q <= sync[SYNC_STAGES-1];
            if (ctrl_wr)
                ctrl <= wdata[1:0];
            // An init write overrides a coincident expiry: no strobe, done cleared.
            if (init_wr) begin
                init    <= wdata;
                count   <= wdata;
                running <= (wdata != '0);
                done    <= 1'b0;
                cout    <= 1'b0;
            end else begin
                cout <= expire;
                if (expire) begin
                    done <= 1'b1;
                    if (ctrl[CTRL_RELOAD])
                        count <= init;
                    else begin
                        count   <= '0;
                        running <= 1'b0;
                    end
                end else begin
                    if (stat_rd)
                        done <= 1'b0;
                    if (dec && count != '0)
                        count <= count - ONE;
                end
            end
        end
    end
endmodule

// File: rtl/minisys_ctc.sv
// Two-channel counter/timer on the Minisys IO path: address decode and read mux.
module minisys_ctc
    import minisys_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clock,
    input  logic         rst,
    minisys_ctc_if.slave bus,
    input  logic         pulse0,
    input  logic         pulse1,
    output logic         cout0,
    output logic         cout1
);
    logic                                 wr;
    logic                                 rd;
    logic [CTC_CHANNELS-1:0]              pulse;
    logic [CTC_CHANNELS-1:0]              cout;
    logic [CTC_CHANNELS-1:0][WIDTH-1:0]   status;
    logic [CTC_CHANNELS-1:0][WIDTH-1:0]   count;

    assign wr    = bus.cs & bus.iow;
    assign rd    = bus.cs & bus.ior;
    assign pulse = {pulse1, pulse0};
    assign cout0 = cout[0];
    assign cout1 = cout[1];

    for (genvar i = 0; i < CTC_CHANNELS; i++) begin : g_ch
        ctc_channel #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clock   (clock),
            .rst     (rst),
            .pulse   (pulse[i]),
            .ctrl_wr (wr && bus.addr == 2'(i)),
            .init_wr (wr && bus.addr == 2'(i + 2)),
            .stat_rd (rd && bus.addr == 2'(i)),
            .wdata   (bus.wdata),
            .status  (status[i]),
            .count   (count[i]),
            .cout    (cout[i])
        );
    end

    always_comb begin
        bus.rdata = '0;
        if (rd) begin
            case (bus.addr)
                CTC_CTRL0: bus.rdata = status[0];
                CTC_CTRL1: bus.rdata = status[1];
                CTC_CNT0:  bus.rdata = count[0];
                CTC_CNT1:  bus.rdata = count[1];
                default:   bus.rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_minisys_ctc.sv
// Directed bench for minisys_ctc; expected values are queued as stimulus is applied.
module tb_minisys_ctc;
    logic clock = 1'b0;
    logic rst;
    logic pulse0, pulse1;
    logic cout0, cout1;
    logic [15:0] exp_q[$];
    int n_chk = 0;
    int n_err = 0;
    logic [15:0] v;

    minisys_ctc_if #(.WIDTH(16)) bus ();

    minisys_ctc #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .clock  (clock),
        .rst    (rst),
        .bus    (bus),
        .pulse0 (pulse0),
        .pulse1 (pulse1),
        .cout0  (cout0),
        .cout1  (cout1)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic push(input logic [15:0] e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $error("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            n_chk++;
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        bus.cs = 1'b1; bus.iow = 1'b1; bus.addr = a; bus.wdata = d;
        tick();
        bus.cs = 1'b0; bus.iow = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        bus.cs = 1'b1; bus.ior = 1'b1; bus.addr = a;
        #1 d = bus.rdata;
        tick();
        bus.cs = 1'b0; bus.ior = 1'b0;
    endtask

    task automatic pulse_train(input int n);
        for (int p = 0; p < n; p++) begin
            pulse0 = 1'b1;
            for (int c = 0; c < 3; c++) begin tick(); chk("cnt_cout0", {15'd0, cout0}); end
            pulse0 = 1'b0;
            for (int c = 0; c < 3; c++) begin tick(); chk("cnt_cout0", {15'd0, cout0}); end
        end
    endtask

    initial begin
        rst = 1'b0; pulse0 = 1'b0; pulse1 = 1'b0;
        bus.cs = 1'b0; bus.iow = 1'b0; bus.ior = 1'b0; bus.addr = 2'd0; bus.wdata = '0;
        @(negedge clock);
        tick(); tick();
        rst = 1'b1;

        // reset state
        for (int a = 0; a < 4; a++) begin
            push(16'h0000);
            bus_read(2'(a), v);
            chk("rst_rdata", v);
        end
        push(16'h0000); chk("rst_cout", {14'd0, cout1, cout0});

        // ch0 timer one-shot, init 5
        bus_write(2'd0, 16'h0000);
        bus_write(2'd2, 16'd5);
        for (int k = 1; k <= 6; k++) push((k == 5) ? 16'd1 : 16'd0);
        for (int k = 1; k <= 6; k++) begin tick(); chk("t0_cout0", {15'd0, cout0}); end
        push(16'h0001); bus_read(2'd0, v); chk("t0_stat_first", v);
        push(16'h0000); bus_read(2'd0, v); chk("t0_stat_second", v);
        push(16'h0000); bus_read(2'd2, v); chk("t0_count", v);

        // ch1 timer auto-reload, init 3
        bus_write(2'd1, 16'h0002);
        bus_write(2'd3, 16'd3);
        for (int k = 1; k <= 20; k++) push((k % 3 == 0) ? 16'd2 : 16'd0);
        for (int k = 1; k <= 20; k++) begin tick(); chk("t1_cout", {14'd0, cout1, cout0}); end
        push(16'h0003); bus_read(2'd1, v); chk("t1_stat_run", v);
        bus_write(2'd3, 16'd0);
        for (int k = 0; k < 6; k++) push(16'd0);
        for (int k = 0; k < 6; k++) begin tick(); chk("t1_stopped", {15'd0, cout1}); end
        push(16'h0000); bus_read(2'd1, v); chk("t1_stat_stop", v);
        push(16'h0000); bus_read(2'd3, v); chk("t1_count_stop", v);

        // ch0 counter mode, init 4
        bus_write(2'd0, 16'h0001);
        bus_write(2'd2, 16'd4);
        for (int k = 0; k < 18; k++) push(16'd0);
        pulse_train(3);
        push(16'd1); bus_read(2'd2, v); chk("c0_count_after3", v);
        push(16'd0); push(16'd0); push(16'd1); push(16'd0); push(16'd0); push(16'd0);
        pulse_train(1);
        push(16'h0001); bus_read(2'd0, v); chk("c0_stat", v);

        // status read in the expiry cycle: set beats clear
        bus_write(2'd0, 16'h0000);
        bus_write(2'd2, 16'd2);
        tick();
        push(16'h0002); bus_read(2'd0, v); chk("rd_at_expiry", v);
        push(16'd1); chk("rd_at_expiry_cout", {15'd0, cout0});
        push(16'h0001); bus_read(2'd0, v); chk("done_after_expiry", v);

        // init write in the expiry cycle wins
        bus_write(2'd2, 16'd2);
        tick();
        bus_write(2'd2, 16'd7);
        push(16'd0); chk("wr_at_expiry_cout", {15'd0, cout0});
        push(16'd7); bus_read(2'd2, v); chk("wr_at_expiry_count", v);
        push(16'h0002); bus_read(2'd0, v); chk("wr_at_expiry_stat", v);

        // single-edge reset mid-count
        bus_write(2'd2, 16'd5);
        tick();
        push(16'd4); bus_read(2'd2, v); chk("pre_rst_count", v);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        push(16'd0); chk("rst_mid_cout", {14'd0, cout1, cout0});
        push(16'd0); bus_read(2'd2, v); chk("rst_mid_count", v);
        push(16'd0); bus_read(2'd0, v); chk("rst_mid_stat", v);
        for (int k = 0; k < 6; k++) push(16'd0);
        for (int k = 0; k < 6; k++) begin tick(); chk("rst_mid_no_cout", {15'd0, cout0}); end

        // held reset keeps everything quiet
        bus_write(2'd1, 16'h0002);
        bus_write(2'd3, 16'd3);
        rst = 1'b0;
        bus.cs = 1'b1; bus.ior = 1'b1; bus.addr = 2'd3;
        for (int k = 0; k < 6; k++) begin push(16'd0); push(16'd0); end
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("hold_rst_cout", {14'd0, cout1, cout0});
            chk("hold_rst_count1", bus.rdata);
        end
        bus.cs = 1'b0; bus.ior = 1'b0;
        rst = 1'b1;

        if (exp_q.size() != 0) begin
            n_chk++;
            n_err++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
